// File: rtl/isa_pkg.sv
// isa_pkg: shared opcode/class/decode types, field positions and the instruction decoder
package isa_pkg;
  typedef logic [4:0] reg_idx_t;
  typedef enum logic [6:0] {
    OP_LOAD    = 7'h03,
    OP_VLD     = 7'h07,
    OP_TEX     = 7'h0B,
    OP_STORE   = 7'h23,
    OP_VST     = 7'h27,
    OP_ATOM_SC = 7'h2F,
    OP_INT     = 7'h33,
    OP_VEC_ALU = 7'h57,
    OP_ATOM_V  = 7'h5B,
    OP_BRANCH  = 7'h63,
    OP_SYSTEM  = 7'h73
  } opcode_t;
  typedef enum logic [1:0] {RC_SCALAR = 2'd0, RC_FP = 2'd1, RC_VEC = 2'd2} reg_class_e;
  typedef struct packed {
    logic       is_valid;
    opcode_t    opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    reg_idx_t   rd;
    reg_idx_t   rs1;
    reg_idx_t   rs2;
    reg_class_e rd_class;
    reg_class_e rs1_class;
    reg_class_e rs2_class;
    logic       uses_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [31:0] imm;
  } decode_ctrl_t;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;
  // Unknown opcodes come back with is_valid=0 and no register uses, so they never touch the scoreboard.
  function automatic decode_ctrl_t decode_inst(input logic [31:0] inst);
    decode_ctrl_t d;
    logic [31:0] imm_i, imm_s, imm_b;
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    d = '0;
    d.opcode   = opcode_t'(inst[6:0]);
    d.rd       = inst[RD_LSB +: 5];
    d.f3       = inst[F3_LSB +: 3];
    d.rs1      = inst[RS1_LSB +: 5];
    d.rs2      = inst[RS2_LSB +: 5];
    d.f7       = inst[F7_LSB +: 7];
    d.is_valid = 1'b1;
    d.uses_rd  = 1'b1;
    d.uses_rs1 = 1'b1;
    d.uses_rs2 = 1'b1;
    d.imm      = imm_i;
    case (inst[6:0])
      OP_INT: if (d.f7[6]) {d.rd_class, d.rs1_class, d.rs2_class} = {RC_FP, RC_FP, RC_FP};
      OP_LOAD, OP_SYSTEM: d.uses_rs2 = 1'b0;
      OP_STORE: begin d.uses_rd = 1'b0; d.imm = imm_s; end
      OP_BRANCH: begin d.uses_rd = 1'b0; d.imm = imm_b; end
      OP_VEC_ALU: begin {d.rd_class, d.rs1_class, d.rs2_class} = {RC_VEC, RC_VEC, RC_VEC}; d.imm = '0; end
      OP_VLD: begin d.rd_class = RC_VEC; d.uses_rs2 = 1'b0; end
      OP_VST: begin d.uses_rd = 1'b0; d.rs2_class = RC_VEC; d.imm = imm_s; end
      OP_TEX: begin d.rd_class = RC_VEC; d.rs1_class = RC_VEC; d.uses_rs2 = 1'b0; end
      OP_ATOM_SC: d.is_valid = 1'b1;
      OP_ATOM_V: begin d.rd_class = RC_VEC; d.rs2_class = RC_VEC; end
      default: begin d.is_valid = 1'b0; d.uses_rd = 1'b0; d.uses_rs1 = 1'b0; d.uses_rs2 = 1'b0; end
    endcase
    return d;
  endfunction
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-class busy bits for in-flight destinations with a combinational hazard query
module issue_scoreboard import isa_pkg::*; #(
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  reg_class_e       set_class,
  input  reg_idx_t         set_rd,
  input  logic             clr_en,
  input  logic [1:0]       clr_class,
  input  reg_idx_t         clr_rd,
  input  logic [2:0]       q_en,
  input  logic [2:0][1:0]  q_class,
  input  logic [2:0][4:0]  q_idx,
  output logic             hazard
);
  logic [3:0][31:0] busy, busy_nxt;
  // Clear first, then set, so a same-cycle set of the same bit wins; scalar x0 is never marked busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_class][clr_rd] = 1'b0;
    if (set_en && !(set_class == RC_SCALAR && set_rd == '0) && int'(set_rd) < NUM_REGS)
      busy_nxt[set_class][set_rd] = 1'b1;
  end
  // Busy state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;
  // Hazard if any used operand (sources or destination) is still in flight.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) hazard = hazard | (q_en[i] & busy[q_class[i]][q_idx[i]]);
  end
endmodule

// File: rtl/decode_issue_buffer.sv
// decode_issue_buffer: fetch FIFO, head decode and in-order hazard-checked issue.
// Optional: DECODE_ILLEGAL_TRAP_EN holds an illegal head and reports it instead of dropping it.
module decode_issue_buffer import isa_pkg::*; #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [31:0]              fetch_inst_i,
  input  logic [PC_W-1:0]          fetch_pc_i,
  input  logic                     flush_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output decode_ctrl_t             issue_ctrl_o,
  output logic [PC_W-1:0]          issue_pc_o,
  input  logic                     wb_valid_i,
  input  logic [1:0]               wb_class_i,
  input  logic [4:0]               wb_rd_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     illegal_o,
  output logic [PC_W-1:0]          illegal_pc_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            empty, full, push, pop, fire, drop, hazard, head_illegal;
  decode_ctrl_t    head;
  assign empty         = count_o == '0;
  assign full          = count_o[AW];
  assign head          = decode_inst(inst_mem[rd_ptr]);
  assign head_illegal  = !empty && !head.is_valid;
  assign fetch_ready_o = !full;
  assign issue_ctrl_o  = head;
  assign issue_pc_o    = pc_mem[rd_ptr];
  assign issue_valid_o = !empty && !flush_i && head.is_valid && !hazard;
  assign fire          = issue_valid_o && issue_ready_i;
  assign push          = fetch_valid_i && !full && !flush_i;
  assign pop           = fire || drop;
  issue_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (fire && head.uses_rd),
    .set_class (head.rd_class),
    .set_rd    (head.rd),
    .clr_en    (wb_valid_i),
    .clr_class (wb_class_i),
    .clr_rd    (wb_rd_i),
    .q_en      ({head.uses_rs2, head.uses_rs1, head.uses_rd}),
    .q_class   ({head.rs2_class, head.rs1_class, head.rd_class}),
    .q_idx     ({head.rs2, head.rs1, head.rd}),
    .hazard    (hazard)
  );
  // FIFO storage; entries need no reset since occupancy gates every use.
  always_ff @(posedge clk)
    if (push) begin
      inst_mem[wr_ptr] <= fetch_inst_i;
      pc_mem[wr_ptr]   <= fetch_pc_i;
    end
  // Pointers and occupancy; flush empties the queue and overrides any push/pop.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic trap_seen, trap_now;
  assign drop     = 1'b0;
  assign trap_now = head_illegal && !trap_seen && !flush_i;
  // Report an illegal head once; the buffer stays stalled on it until a flush re-arms the trap.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trap_seen    <= 1'b0;
      illegal_o    <= 1'b0;
      illegal_pc_o <= '0;
    end else begin
      trap_seen <= flush_i ? 1'b0 : (trap_seen | head_illegal);
      illegal_o <= trap_now;
      if (trap_now) illegal_pc_o <= pc_mem[rd_ptr];
    end
`else
  assign drop         = head_illegal && !flush_i;
  assign illegal_o    = 1'b0;
  assign illegal_pc_o = '0;
`endif
endmodule

// File: tb/tb_decode_issue_buffer.sv
// tb_decode_issue_buffer: directed scenarios plus a randomized run against a queue-based reference model
module tb_decode_issue_buffer;
  import isa_pkg::*;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch_valid = 1'b0, fetch_ready, flush = 1'b0, issue_valid, issue_ready = 1'b0;
  logic [31:0] fetch_inst = '0;
  logic [PC_W-1:0] fetch_pc = '0, issue_pc, illegal_pc;
  decode_ctrl_t issue_ctrl;
  logic wb_valid = 1'b0, illegal;
  logic [1:0] wb_class = '0;
  logic [4:0] wb_rd = '0;
  logic [2:0] count;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  decode_issue_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .fetch_inst_i(fetch_inst), .fetch_pc_i(fetch_pc), .flush_i(flush), .issue_valid_o(issue_valid),
    .issue_ready_i(issue_ready), .issue_ctrl_o(issue_ctrl), .issue_pc_o(issue_pc),
    .wb_valid_i(wb_valid), .wb_class_i(wb_class), .wb_rd_i(wb_rd), .count_o(count),
    .illegal_o(illegal), .illegal_pc_o(illegal_pc)
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, op};
  endfunction

  function automatic int cls(input byte c);
    return c == "F" ? 1 : c == "V" ? 2 : 0;
  endfunction

  // Reference decode: per-opcode operand pattern (rd,rs1,rs2; S/F/V class or '-' unused) and immediate form.
  function automatic bit ref_dec(input logic [31:0] i, output string pat, output logic [31:0] imm);
    byte k;
    pat = "---";
    k = "0";
    case (i[6:0])
      OP_INT:     begin pat = i[31] ? "FFF" : "SSS"; k = "I"; end
      OP_LOAD:    begin pat = "SS-"; k = "I"; end
      OP_STORE:   begin pat = "-SS"; k = "S"; end
      OP_BRANCH:  begin pat = "-SS"; k = "B"; end
      OP_SYSTEM:  begin pat = "SS-"; k = "I"; end
      OP_VEC_ALU: begin pat = "VVV"; k = "0"; end
      OP_VLD:     begin pat = "VS-"; k = "I"; end
      OP_VST:     begin pat = "-SV"; k = "S"; end
      OP_TEX:     begin pat = "VV-"; k = "I"; end
      OP_ATOM_SC: begin pat = "SSS"; k = "I"; end
      OP_ATOM_V:  begin pat = "VSV"; k = "I"; end
      default: begin imm = '0; return 1'b0; end
    endcase
    imm = k == "I" ? 32'($signed(i[31:20])) :
          k == "S" ? 32'($signed({i[31:25], i[11:7]})) :
          k == "B" ? 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})) : 32'd0;
    return 1'b1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_valid = 0; fetch_inst = '0; fetch_pc = '0; flush = 0;
    issue_ready = 0; wb_valid = 0; wb_class = '0; wb_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    fetch_valid = 1; fetch_inst = mk(OP_INT, 1, 0, 0); fetch_pc = 32'h10;
    cyc(); cyc();
    fetch_valid = 0;
    @(negedge clk);
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL reset_pre_count got %0d exp 2", count); end
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", fetch_ready); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid got %b exp 0", issue_valid); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    n_checks++; if (illegal_pc !== '0) begin n_fail++; $display("FAIL reset_illegal_pc got %h exp 0", illegal_pc); end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    issue_ready = 1;
    for (int k = 0; k <= 4; k++) begin
      fetch_valid = k < 4;
      fetch_inst = mk(OP_INT, 5'(k + 1), 0, 0);
      fetch_pc = 32'h100 + 32'(4 * k);
      @(negedge clk);
      if (k > 0) begin
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", k, issue_valid); end
        n_checks++; if (issue_pc !== 32'h100 + 32'(4 * (k - 1))) begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", k, issue_pc, 32'h100 + 32'(4 * (k - 1))); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d exp 1", k, count); end
      end
      cyc();
    end
    @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_drain got %0d exp 0", count); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle got %b exp 0", issue_valid); end
    cyc();
  endtask

  task automatic test_full();
    do_reset();
    issue_ready = 0; fetch_valid = 1;
    for (int k = 0; k <= 4; k++) begin
      fetch_inst = mk(OP_INT, 5'(k + 1), 0, 0);
      fetch_pc = 32'h100 + 32'(4 * k);
      if (k < 4) cyc();
    end
    @(negedge clk);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", count); end
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", fetch_ready); end
    n_checks++; if (issue_pc !== 32'h100) begin n_fail++; $display("FAIL full_head_pc got %h exp 100", issue_pc); end
    cyc();
    @(negedge clk);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_held_count got %0d exp 4", count); end
    n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h100) begin n_fail++; $display("FAIL full_stable got v=%b pc=%h exp v=1 pc=100", issue_valid, issue_pc); end
    issue_ready = 1;
    #1;
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_passthru got %b exp 0", fetch_ready); end
    cyc();
    issue_ready = 0;
    @(negedge clk);
    n_checks++; if (count !== 3'd3 || fetch_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop got cnt=%0d rdy=%b exp cnt=3 rdy=1", count, fetch_ready); end
    n_checks++; if (issue_pc !== 32'h104) begin n_fail++; $display("FAIL full_next_head got %h exp 104", issue_pc); end
    cyc();
    fetch_valid = 0;
    @(negedge clk);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_refill got %0d exp 4", count); end
    cyc();
  endtask

  task automatic test_raw();
    do_reset();
    issue_ready = 1; fetch_valid = 1;
    fetch_inst = mk(OP_INT, 5, 0, 0); fetch_pc = 32'h200;
    cyc();
    fetch_inst = mk(OP_INT, 6, 5, 0); fetch_pc = 32'h204;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h200) begin n_fail++; $display("FAIL raw_first got v=%b pc=%h exp v=1 pc=200", issue_valid, issue_pc); end
    cyc();
    fetch_valid = 0;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall got %b exp 0", issue_valid); end
    cyc();
    wb_valid = 1; wb_class = RC_SCALAR; wb_rd = 5;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass got %b exp 0", issue_valid); end
    cyc();
    wb_valid = 0;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h204) begin n_fail++; $display("FAIL raw_release got v=%b pc=%h exp v=1 pc=204", issue_valid, issue_pc); end
    cyc();
  endtask

  task automatic test_x0_vec();
    do_reset();
    issue_ready = 1;
    for (int k = 0; k <= 3; k++) begin
      fetch_valid = k < 3;
      fetch_inst = mk(OP_INT, 0, 0, 0);
      fetch_pc = 32'h400 + 32'(4 * k);
      @(negedge clk);
      if (k > 0) begin
        n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h400 + 32'(4 * (k - 1))) begin n_fail++; $display("FAIL x0_issue[%0d] got v=%b pc=%h", k, issue_valid, issue_pc); end
      end
      cyc();
    end
    fetch_valid = 1; fetch_inst = mk(OP_VLD, 3, 0, 0); fetch_pc = 32'h500;
    cyc();
    fetch_inst = mk(OP_VEC_ALU, 1, 3, 0); fetch_pc = 32'h504;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b1 || issue_ctrl.rd_class !== RC_VEC) begin n_fail++; $display("FAIL vld_issue got v=%b cls=%0d exp v=1 cls=2", issue_valid, issue_ctrl.rd_class); end
    cyc();
    fetch_valid = 0; wb_valid = 1; wb_class = RC_SCALAR; wb_rd = 3;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL vec_stall got %b exp 0", issue_valid); end
    cyc();
    wb_class = RC_VEC;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL vec_wrong_class got %b exp 0", issue_valid); end
    cyc();
    wb_valid = 0;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h504) begin n_fail++; $display("FAIL vec_release got v=%b pc=%h exp v=1 pc=504", issue_valid, issue_pc); end
    cyc();
  endtask

  task automatic test_flush();
    do_reset();
    issue_ready = 1; fetch_valid = 1;
    fetch_inst = mk(OP_INT, 7, 0, 0); fetch_pc = 32'h600;
    cyc();
    for (int k = 1; k <= 3; k++) begin
      fetch_inst = mk(OP_INT, 5'(k), 0, 0); fetch_pc = 32'h600 + 32'(4 * k);
      cyc();
      issue_ready = 0;
    end
    fetch_inst = mk(OP_INT, 9, 0, 0); fetch_pc = 32'h6F0;
    @(negedge clk);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    issue_ready = 1; flush = 1;
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_gate got %b exp 0", issue_valid); end
    cyc();
    flush = 0; fetch_inst = mk(OP_INT, 8, 7, 0); fetch_pc = 32'h700;
    @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
    cyc();
    fetch_valid = 0;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_busy_kept got %b exp 0", issue_valid); end
    cyc();
    wb_valid = 1; wb_class = RC_SCALAR; wb_rd = 7;
    cyc();
    wb_valid = 0;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h700) begin n_fail++; $display("FAIL flush_reader got v=%b pc=%h exp v=1 pc=700", issue_valid, issue_pc); end
    cyc();
  endtask

  task automatic test_illegal();
    do_reset();
    issue_ready = 1; fetch_valid = 1;
    fetch_inst = mk(7'h7F, 0, 0, 0); fetch_pc = 32'h300;
    cyc();
    fetch_inst = mk(OP_INT, 1, 0, 0); fetch_pc = 32'h304;
    @(negedge clk);
    n_checks++; if (issue_valid !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL ill_head got v=%b ill=%b exp 0 0", issue_valid, illegal); end
    cyc();
    fetch_valid = 0;
    @(negedge clk);
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_checks++; if (illegal !== 1'b1 || illegal_pc !== 32'h300) begin n_fail++; $display("FAIL ill_trap got ill=%b pc=%h exp 1 300", illegal, illegal_pc); end
    n_checks++; if (issue_valid !== 1'b0 || count !== 3'd2) begin n_fail++; $display("FAIL ill_hold got v=%b cnt=%0d exp 0 2", issue_valid, count); end
    cyc();
    @(negedge clk);
    n_checks++; if (illegal !== 1'b0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL ill_once got ill=%b v=%b exp 0 0", illegal, issue_valid); end
    flush = 1;
    cyc();
    flush = 0;
`else
    n_checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h304) begin n_fail++; $display("FAIL ill_drop got v=%b pc=%h exp v=1 pc=304", issue_valid, issue_pc); end
    n_checks++; if (illegal !== 1'b0 || illegal_pc !== '0) begin n_fail++; $display("FAIL ill_quiet got ill=%b pc=%h exp 0 0", illegal, illegal_pc); end
    cyc();
`endif
    @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL ill_empty got %0d exp 0", count); end
    cyc();
  endtask

  task automatic test_random();
    logic [31:0] q_inst[$];
    logic [PC_W-1:0] q_pc[$];
    bit busy_m [4][32];
    int cand[$];
    logic [6:0] ops [11] = '{OP_INT, OP_LOAD, OP_STORE, OP_BRANCH, OP_SYSTEM, OP_VEC_ALU,
                             OP_VLD, OP_VST, OP_TEX, OP_ATOM_SC, OP_ATOM_V};
    logic [PC_W-1:0] pcn = 32'h1000;
    logic [31:0] h, imm;
    logic [6:0] op;
    string pat;
    bit ok, haz, exp_v, pop, push;
    int idx[3], sel;
    do_reset();
    for (int c = 0; c < 4; c++) for (int r = 0; r < 32; r++) busy_m[c][r] = 0;
    repeat (2000) begin
      op = ops[$urandom_range(0, 10)];
`ifndef DECODE_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 15) == 0) op = 7'h7F;
`endif
      fetch_valid = $urandom_range(0, 3) != 0;
      fetch_inst = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                    5'($urandom_range(0, 7)), op};
      fetch_pc = pcn; pcn += 4;
      issue_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 49) == 0;
      cand.delete();
      for (int c = 0; c < 3; c++) for (int r = 0; r < 32; r++) if (busy_m[c][r]) cand.push_back(c * 32 + r);
      wb_valid = 0;
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        sel = cand[$urandom_range(0, cand.size() - 1)];
        wb_valid = 1; wb_class = 2'(sel / 32); wb_rd = 5'(sel % 32);
      end else if ($urandom_range(0, 7) == 0) begin
        wb_valid = 1; wb_class = 2'($urandom_range(0, 2)); wb_rd = 5'($urandom_range(0, 7));
      end
      @(negedge clk);
      ok = 0; haz = 0; h = '0; pat = "---"; imm = '0;
      if (q_inst.size() > 0) begin
        h = q_inst[0];
        ok = ref_dec(h, pat, imm);
        idx = '{int'(h[11:7]), int'(h[19:15]), int'(h[24:20])};
        for (int j = 0; j < 3; j++) if (pat[j] != "-" && busy_m[cls(pat[j])][idx[j]]) haz = 1;
      end
      exp_v = q_inst.size() > 0 && !flush && ok && !haz;
      n_checks++; if (count !== 3'(q_inst.size())) begin n_fail++; $display("FAIL rnd_count got %0d exp %0d", count, q_inst.size()); end
      n_checks++; if (fetch_ready !== (q_inst.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready got %b exp %b", fetch_ready, q_inst.size() < DEPTH); end
      n_checks++; if (issue_valid !== exp_v) begin n_fail++; $display("FAIL rnd_valid got %b exp %b inst=%h", issue_valid, exp_v, h); end
      if (exp_v) begin
        n_checks++; if (issue_pc !== q_pc[0]) begin n_fail++; $display("FAIL rnd_pc got %h exp %h", issue_pc, q_pc[0]); end
        n_checks++; if (issue_ctrl.imm !== imm) begin n_fail++; $display("FAIL rnd_imm got %h exp %h inst=%h", issue_ctrl.imm, imm, h); end
        n_checks++; if (issue_ctrl.uses_rd !== (pat[0] != "-")) begin n_fail++; $display("FAIL rnd_uses_rd got %b inst=%h", issue_ctrl.uses_rd, h); end
        if (pat[0] != "-") begin
          n_checks++; if (int'(issue_ctrl.rd_class) != cls(pat[0])) begin n_fail++; $display("FAIL rnd_rd_class got %0d exp %0d", issue_ctrl.rd_class, cls(pat[0])); end
        end
      end
      pop = !flush && q_inst.size() > 0 && ((exp_v && issue_ready) || !ok);
      push = fetch_valid && q_inst.size() < DEPTH && !flush;
      if (wb_valid) busy_m[wb_class][wb_rd] = 0;
      if (exp_v && issue_ready && pat[0] != "-" && !(cls(pat[0]) == 0 && h[11:7] == 0)) busy_m[cls(pat[0])][h[11:7]] = 1;
      if (flush) begin q_inst.delete(); q_pc.delete(); end
      else begin
        if (pop) begin void'(q_inst.pop_front()); void'(q_pc.pop_front()); end
        if (push) begin q_inst.push_back(fetch_inst); q_pc.push_back(fetch_pc); end
      end
      cyc();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_raw();
    test_x0_vec();
    test_flush();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
